// File: rtl/dma_bus_if.sv
// Command, stream and 6809 bus signals between the DMA bus master and its surroundings.
// The master modport is the engine side; the slave modport is the host/bus side.
interface dma_bus_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              error;
    logic              ba;
    logic              bs;
    logic              halt_n;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_addr_oe;
    logic [DATA_W-1:0] bus_data_out;
    logic              bus_data_oe;
    logic [DATA_W-1:0] bus_data_in;
    logic              bus_rw;
    logic              bus_we_n;
    logic              bus_re_n;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, ba, bs, bus_data_in,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, error, halt_n,
               bus_addr, bus_addr_oe, bus_data_out, bus_data_oe, bus_rw, bus_we_n, bus_re_n
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, ba, bs, bus_data_in,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, error, halt_n,
               bus_addr, bus_addr_oe, bus_data_out, bus_data_oe, bus_rw, bus_we_n, bus_re_n
    );
endinterface

// File: rtl/dma_bus_master.sv
// 6809 bus initiator: halts the CPU, waits for BA=BS=1, then runs byte-wide
// read/write bursts on the shared bus and releases it again.
module dma_bus_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GRANT_TIMEOUT = 4095
) (
    input  logic      clk_i,
    input  logic      reset_i,
    dma_bus_if.master bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned WAIT_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SETUP, S_STROBE, S_HOLD, S_RELEASE
    } state_e;

    state_e            state_q;
    logic [1:0]        ba_sync_q;
    logic [1:0]        bs_sync_q;
    logic              write_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [WAIT_W-1:0] wait_q;
    logic [STRB_W-1:0] strb_q;

    logic              cmd_ready_q;
    logic              wr_ready_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;
    logic              error_q;
    logic              halt_n_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_addr_oe_q;
    logic [DATA_W-1:0] bus_data_q;
    logic              bus_data_oe_q;
    logic              bus_rw_q;
    logic              bus_we_n_q;
    logic              bus_re_n_q;

    logic              grant_c;
    logic              ba_c;

    assign addr_d  = addr_q + ADDR_W'(1);
    assign ba_c    = ba_sync_q[1];
    assign grant_c = ba_sync_q[1] & bs_sync_q[1];

    // BA/BS come straight from the CPU pins
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ba_sync_q <= '0;
            bs_sync_q <= '0;
        end else begin
            ba_sync_q <= {ba_sync_q[0], bus.ba};
            bs_sync_q <= {bs_sync_q[0], bus.bs};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            wait_q        <= '0;
            strb_q        <= '0;
            cmd_ready_q   <= 1'b0;
            wr_ready_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            halt_n_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_addr_oe_q <= 1'b0;
            bus_data_q    <= '0;
            bus_data_oe_q <= 1'b0;
            bus_rw_q      <= 1'b1;
            bus_we_n_q    <= 1'b1;
            bus_re_n_q    <= 1'b1;
        end else begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        write_q     <= bus.cmd_write;
                        addr_q      <= bus.cmd_addr;
                        cnt_q       <= (bus.cmd_len == '0) ? CNT_W'(256) : {1'b0, bus.cmd_len};
                        wait_q      <= '0;
                        err_q       <= 1'b0;
                        halt_n_q    <= 1'b0;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (grant_c) begin
                        bus_addr_oe_q <= 1'b1;
                        bus_addr_q    <= addr_q;
                        bus_rw_q      <= ~write_q;
                        wr_ready_q    <= write_q;
                        state_q       <= S_SETUP;
                    end else if (wait_q == WAIT_W'(GRANT_TIMEOUT)) begin
                        err_q    <= 1'b1;
                        halt_n_q <= 1'b1;
                        state_q  <= S_RELEASE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_SETUP: begin
                    // Writes wait here for the next byte; reads strobe after one cycle
                    if (!write_q) begin
                        bus_re_n_q <= 1'b0;
                        strb_q     <= '0;
                        state_q    <= S_STROBE;
                    end else if (bus.wr_valid && wr_ready_q) begin
                        wr_ready_q    <= 1'b0;
                        bus_data_q    <= bus.wr_data;
                        bus_data_oe_q <= 1'b1;
                        bus_we_n_q    <= 1'b0;
                        strb_q        <= '0;
                        state_q       <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (strb_q == STRB_W'(STROBE_CYCLES - 1)) begin
                        bus_we_n_q <= 1'b1;
                        bus_re_n_q <= 1'b1;
                        if (!write_q) begin
                            rd_data_q  <= bus.bus_data_in;
                            rd_valid_q <= 1'b1;
                        end
                        state_q <= S_HOLD;
                    end else begin
                        strb_q <= strb_q + STRB_W'(1);
                    end
                end
                S_HOLD: begin
                    addr_q <= addr_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bus_addr_oe_q <= 1'b0;
                        bus_data_oe_q <= 1'b0;
                        bus_rw_q      <= 1'b1;
                        halt_n_q      <= 1'b1;
                        state_q       <= S_RELEASE;
                    end else begin
                        bus_addr_q    <= addr_d;
                        bus_data_oe_q <= 1'b0;
                        wr_ready_q    <= write_q;
                        state_q       <= S_SETUP;
                    end
                end
                S_RELEASE: begin
                    // A timed-out request never got the bus, so there is nothing to wait for
                    if (err_q) begin
                        error_q     <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (!ba_c) begin
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.wr_ready     = wr_ready_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.halt_n       = halt_n_q;
    assign bus.bus_addr     = bus_addr_q;
    assign bus.bus_addr_oe  = bus_addr_oe_q;
    assign bus.bus_data_out = bus_data_q;
    assign bus.bus_data_oe  = bus_data_oe_q;
    assign bus.bus_rw       = bus_rw_q;
    assign bus.bus_we_n     = bus_we_n_q;
    assign bus.bus_re_n     = bus_re_n_q;
endmodule

// File: tb/tb_dma_bus_master.sv
// Randomized scoreboard bench for dma_bus_master with a CPU grant model,
// an SRAM responder and a queue-based reference of expected bus activity.
module tb_dma_bus_master;
    localparam int unsigned STROBE_CYCLES = 2;
    localparam int unsigned GRANT_TIMEOUT = 16;
    localparam int          BYTE_CYC      = STROBE_CYCLES + 2;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   violations = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_bus_if bif ();

    dma_bus_master #(
        .STROBE_CYCLES(STROBE_CYCLES),
        .GRANT_TIMEOUT(GRANT_TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bif)
    );

    logic [7:0] mem       [0:65535];
    logic [7:0] model_mem [0:65535];
    bus_exp_t   exp_bus [$];
    logic [7:0] exp_rd  [$];
    int         exp_term[$];
    logic [7:0] wr_q    [$];
    logic [7:0] fixed   [$];
    int         strobe_starts[$];

    int stall_at = -1;
    int stall_left = 0;
    int consumed = 0;
    int gap_pct = 0;
    int grant_dly = 3;
    bit deny = 1'b0;

    assign bif.bus_data_in = mem[bif.bus_addr];

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_chk(input string name);
        checks++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    function automatic logic [42:0] outs();
        return {bif.cmd_ready, bif.halt_n, bif.bus_we_n, bif.bus_re_n, bif.bus_rw,
                bif.bus_addr_oe, bif.bus_data_oe, bif.bus_addr, bif.bus_data_out,
                bif.rd_data, bif.wr_ready, bif.rd_valid, bif.done, bif.error};
    endfunction

    localparam logic [42:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                       16'h0000, 8'h00, 8'h00, 4'b0000};

    // CPU: grants the bus a while after HALT, drops BA a while after HALT is released
    initial begin : cpu_model
        int gnt_cnt;
        int rel_cnt;
        gnt_cnt = 0;
        rel_cnt = 0;
        bif.ba = 1'b0;
        bif.bs = 1'b0;
        forever begin
            @(negedge clk);
            if (!bif.halt_n) begin
                rel_cnt = 0;
                if (!deny && !bif.ba) begin
                    if (gnt_cnt >= grant_dly) begin
                        bif.ba = 1'b1;
                        bif.bs = 1'b1;
                    end else gnt_cnt++;
                end
            end else begin
                gnt_cnt = 0;
                if (bif.ba) begin
                    if (rel_cnt >= 2) begin
                        bif.ba = 1'b0;
                        bif.bs = 1'b0;
                        rel_cnt = 0;
                    end else rel_cnt++;
                end
            end
        end
    end

    // Write-data source with optional random gaps and a targeted stall
    initial begin : feeder
        bit hs_pending;
        hs_pending = 1'b0;
        bif.wr_valid = 1'b0;
        bif.wr_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                hs_pending = 1'b0;
                bif.wr_valid = 1'b0;
            end else begin
                if (hs_pending && wr_q.size() > 0) begin
                    void'(wr_q.pop_front());
                    consumed++;
                end
                if (wr_q.size() == 0) bif.wr_valid = 1'b0;
                else if (consumed == stall_at && stall_left > 0 && bif.wr_ready) begin
                    stall_left--;
                    bif.wr_valid = 1'b0;
                end else if ($urandom_range(99) < gap_pct) bif.wr_valid = 1'b0;
                else begin
                    bif.wr_valid = 1'b1;
                    bif.wr_data = wr_q[0];
                end
                hs_pending = bif.wr_valid && bif.wr_ready;
            end
        end
    end

    // Monitor: SRAM responder, scoreboard pops and bus invariants
    initial begin : monitor
        bit         we_prev, re_prev, halt_prev;
        int         strb_len, halt_fall_cyc, k, diff;
        logic [15:0] strb_addr;
        logic [7:0]  last_rd;
        bus_exp_t    e;
        for (int i = 0; i < 65536; i++) mem[i] = init_byte(16'(i));
        we_prev = 1'b1; re_prev = 1'b1; halt_prev = 1'b1;
        strb_len = 0; halt_fall_cyc = 0; strb_addr = '0; last_rd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                we_prev = 1'b1; re_prev = 1'b1; halt_prev = 1'b1;
                strb_len = 0; last_rd = '0;
            end else begin
                if ((bif.bus_data_oe && (!bif.bus_addr_oe || bif.bus_rw)) ||
                    ((bif.bus_addr_oe || bif.bus_data_oe) && bif.halt_n) ||
                    (!bif.bus_we_n && !bif.bus_re_n) || (bif.done && bif.error) ||
                    (!bif.bus_we_n && (!bif.bus_data_oe || bif.bus_rw)) ||
                    (!bif.bus_re_n && (!bif.bus_rw || !bif.bus_addr_oe)) ||
                    (!bif.rd_valid && bif.rd_data !== last_rd))
                    violations++;
                if (!bif.bus_we_n) mem[bif.bus_addr] = bif.bus_data_out;

                if ((!bif.bus_we_n && we_prev) || (!bif.bus_re_n && re_prev)) begin
                    strobe_starts.push_back(cyc);
                    strb_len = 1;
                    strb_addr = bif.bus_addr;
                    if (exp_bus.size() == 0) fail_chk("unexpected_strobe");
                    else begin
                        e = exp_bus.pop_front();
                        check("strobe", {bif.bus_rw, bif.bus_addr,
                              bif.bus_rw ? 8'h00 : bif.bus_data_out}, {e.rw, e.addr, e.data});
                    end
                end else if (!bif.bus_we_n || !bif.bus_re_n) begin
                    strb_len++;
                    if (bif.bus_addr !== strb_addr) violations++;
                end
                if ((bif.bus_we_n && !we_prev) || (bif.bus_re_n && !re_prev))
                    check("strobe_len", strb_len, STROBE_CYCLES);

                if (bif.rd_valid) begin
                    last_rd = bif.rd_data;
                    if (exp_rd.size() == 0) fail_chk("unexpected_rd_valid");
                    else check("rd_data", bif.rd_data, exp_rd.pop_front());
                end

                if (!bif.halt_n && halt_prev) halt_fall_cyc = cyc;

                if (bif.done || bif.error) begin
                    if (exp_term.size() == 0) fail_chk("unexpected_done_error");
                    else begin
                        k = exp_term.pop_front();
                        check("term_kind", {bif.done, bif.error}, (k == 0) ? 2'b10 : 2'b01);
                        check("term_bus_state", {bif.cmd_ready, bif.halt_n,
                              bif.bus_addr_oe, bif.bus_data_oe}, 4'b1100);
                        if (bif.error) begin
                            diff = cyc - halt_fall_cyc;
                            checks++;
                            if (diff >= int'(GRANT_TIMEOUT) + 1 && diff <= int'(GRANT_TIMEOUT) + 2)
                                passed++;
                            else $display("FAIL err_latency: got %0d cycles expected %0d..%0d",
                                          diff, GRANT_TIMEOUT + 1, GRANT_TIMEOUT + 2);
                        end
                    end
                end
                we_prev = bif.bus_we_n;
                re_prev = bif.bus_re_n;
                halt_prev = bif.halt_n;
            end
        end
    end

    // Reference model: expand a command into its byte-level bus transactions
    task automatic issue(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                         input bit exp_err);
        int n, t;
        logic [15:0] a;
        logic [7:0]  d;
        n = (len == 0) ? 256 : int'(len);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 16'(i);
                if (wr) begin
                    d = (fixed.size() > 0) ? fixed.pop_front() : 8'($urandom);
                    model_mem[a] = d;
                    wr_q.push_back(d);
                    exp_bus.push_back({1'b0, a, d});
                end else begin
                    exp_bus.push_back({1'b1, a, 8'h00});
                    exp_rd.push_back(model_mem[a]);
                end
            end
        end
        exp_term.push_back(exp_err ? 1 : 0);
        t = 0;
        @(negedge clk);
        while (!bif.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bif.cmd_ready) fail_chk("cmd_ready_timeout");
        bif.cmd_valid = 1'b1;
        bif.cmd_write = wr;
        bif.cmd_addr = addr;
        bif.cmd_len = len;
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        bif.cmd_addr = 16'($urandom);
        bif.cmd_len = 8'($urandom);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (exp_term.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_term.size() != 0) begin
            fail_chk(name);
            exp_term.delete();
        end
        check({name, "_bus_q_empty"}, exp_bus.size(), 0);
        check({name, "_rd_q_empty"}, exp_rd.size(), 0);
    endtask

    task automatic check_gaps(input string name, input int g0, input int g1);
        check({name, "_nstrobes"}, strobe_starts.size(), 3);
        if (strobe_starts.size() == 3) begin
            check({name, "_gap0"}, strobe_starts[1] - strobe_starts[0], g0);
            check({name, "_gap1"}, strobe_starts[2] - strobe_starts[1], g1);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        int t;
        for (int i = 0; i < 65536; i++) model_mem[i] = init_byte(16'(i));
        bif.cmd_valid = 1'b0;
        bif.cmd_write = 1'b0;
        bif.cmd_addr = '0;
        bif.cmd_len = '0;

        #23;
        check("reset_values", outs(), RST_VEC);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("cmd_ready_after_reset", bif.cmd_ready, 1'b1);

        // Write burst with fixed data, grant after 3 cycles
        grant_dly = 3;
        fixed = '{8'hA5, 8'h5A, 8'hFF};
        strobe_starts.delete();
        issue(1'b1, 16'h1000, 8'd3, 1'b0);
        wait_done("write_burst");
        check_gaps("write_burst", BYTE_CYC, BYTE_CYC);

        // Read burst returning 11, 22
        fixed = '{8'h11, 8'h22};
        issue(1'b1, 16'h2000, 8'd2, 1'b0);
        wait_done("preload");
        issue(1'b0, 16'h2000, 8'd2, 1'b0);
        wait_done("read_burst");

        // Address wrap and 256-byte length
        issue(1'b0, 16'hFFFF, 8'd0, 1'b0);
        wait_done("wrap_256");

        // Second byte stalled 5 cycles; a stray cmd_valid mid-burst must be ignored
        strobe_starts.delete();
        stall_at = consumed + 1;
        stall_left = 5;
        issue(1'b1, 16'h4000, 8'd3, 1'b0);
        bif.cmd_valid = 1'b1;
        bif.cmd_addr = 16'hDEAD;
        repeat (5) @(negedge clk);
        bif.cmd_valid = 1'b0;
        wait_done("write_stall");
        check_gaps("write_stall", BYTE_CYC + 5, BYTE_CYC);
        stall_at = -1;

        issue(1'b0, 16'h1000, 8'd3, 1'b0);
        wait_done("readback_1000");
        issue(1'b0, 16'h4000, 8'd3, 1'b0);
        wait_done("readback_4000");

        // Grant timeout
        deny = 1'b1;
        strobe_starts.delete();
        issue(1'b0, 16'h5000, 8'd2, 1'b1);
        wait_done("grant_timeout");
        check("timeout_no_strobes", strobe_starts.size(), 0);
        deny = 1'b0;
        issue(1'b0, 16'h5000, 8'd2, 1'b0);
        wait_done("after_timeout");

        // Asynchronous reset in the middle of a write strobe
        issue(1'b1, 16'h3000, 8'd4, 1'b0);
        t = 0;
        while (bif.bus_we_n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bif.bus_we_n) fail_chk("mid_strobe_wait");
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_strobe", outs(), RST_VEC);
        exp_bus.delete();
        exp_rd.delete();
        exp_term.delete();
        wr_q.delete();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 16'h6000, 8'd2, 1'b0);
        wait_done("post_reset_write");
        issue(1'b0, 16'h6000, 8'd2, 1'b0);
        wait_done("post_reset_read");

        // Randomized bursts
        for (int n = 0; n < 10; n++) begin
            grant_dly = $urandom_range(0, 8);
            gap_pct = $urandom_range(0, 40);
            issue(1'($urandom), 16'h8000 | 16'($urandom_range(0, 16'h7FFF)),
                  8'($urandom_range(1, 6)), 1'b0);
            wait_done("random_burst");
        end
        gap_pct = 0;

        repeat (10) @(negedge clk);
        check("wr_q_drained", wr_q.size(), 0);
        check("term_q_empty", exp_term.size(), 0);
        check("bus_invariants", violations, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dma_bus_master.md
# dma_bus_master

Bus-initiator engine that takes the 6809 bus away from the CPU (HALT, wait for BA=BS=1) and runs byte-wide read/write bursts to SRAM/flash on the shared address/data bus. It is the initiator counterpart to the existing memory controller/address decoder, which stay bus responders. It sits between the FT2232 host-command logic (command/data streams) and the external bus pins, clocked from the internal 12 MHz OSCH.

## Interface
- STROBE_CYCLES, 2: cycles the read/write strobe is held low per byte (1..15).
- GRANT_TIMEOUT, 4095: max cycles waiting for BA=BS=1 before aborting.
- clk  in  1  system clock (12 MHz internal oscillator).
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle and accepting; accept when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = bus write burst, 0 = read burst.
- cmd_addr  in  16  start address.
- cmd_len  in  8  byte count; 0 means 256.
- wr_data  in  8  write byte stream.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  byte consumed when wr_valid & wr_ready.
- rd_data  out  8  read byte.
- rd_valid  out  1  one-cycle pulse per read byte; no backpressure.
- done  out  1  one-cycle pulse at burst completion (bus released).
- error  out  1  one-cycle pulse on grant timeout.
- ba, bs  in  1 each  6809 bus-available/bus-status (asynchronous, 2-flop synchronized internally).
- halt_n  out  1  to 6809 HALT, active low.
- bus_addr  out  16  driven address.
- bus_addr_oe  out  1  address driver enable.
- bus_data_out  out  8  write data.
- bus_data_oe  out  1  data driver enable (writes only).
- bus_data_in  in  8  read data from bus.
- bus_rw  out  1  1 = read, 0 = write.
- bus_we_n, bus_re_n  out  1 each  active-low strobes.

## Operation
- States: IDLE, REQ, SETUP, STROBE, HOLD, RELEASE.
- IDLE: cmd_ready=1. On accept, latch write flag, addr, count (0 -> 256, 9-bit counter); go REQ.
- REQ: halt_n=0. When synced ba&bs=1 -> SETUP. Wait counter reaches GRANT_TIMEOUT -> RELEASE with error flagged.
- SETUP: bus_addr_oe=1, bus_addr=current addr, bus_rw=~write. Write: wr_ready=1; stay in SETUP until wr_valid, latch wr_data into bus_data_out, bus_data_oe=1, -> STROBE. Read: -> STROBE after 1 cycle.
- STROBE: bus_we_n=0 (write) or bus_re_n=0 (read) for STROBE_CYCLES cycles. Read data captured from bus_data_in on last STROBE cycle.
- HOLD: strobes high, address/data still driven 1 cycle. Read: rd_valid=1 with captured byte. Addr+1 (16-bit wrap: 0xFFFF -> 0x0000), count-1. Count reaches 0 -> RELEASE else SETUP.
- RELEASE: all oe=0, halt_n=1. When synced ba=0 (or after error path immediately) -> IDLE, pulsing done (normal) or error (timeout); never both.
- cmd_valid ignored outside IDLE. Drivers (bus_addr_oe, bus_data_oe) only ever 1 in SETUP/STROBE/HOLD.
- Reset mid-burst: immediately return to reset values; bus released; no done/error pulse; partial burst discarded.

## Timing
- Reset values: cmd_ready=0 during reset then 1 in IDLE; halt_n=1; bus_we_n=bus_re_n=1; bus_rw=1; all oe=0; bus_addr=0; bus_data_out=0; rd_data=0; wr_ready=rd_valid=done=error=0.
- halt_n falls the cycle after accept. ba/bs see 2-cycle sync latency.
- Per byte (write data available): 1 SETUP + STROBE_CYCLES + 1 HOLD = 4 cycles at default.
- rd_valid asserted in HOLD cycle, rd_data stable until next rd_valid.
- done asserted the cycle IDLE is re-entered; cmd_ready 1 same cycle.
- Timeout: error pulses GRANT_TIMEOUT+1..+2 cycles after halt_n falls; halt_n back to 1 by then.

## Test plan
- Write burst: addr 0x1000, len 3, data A5/5A/FF always valid, ba=bs=1 after 3 cycles -> three strobes, bus_addr 1000/1001/1002 with matching bus_data_out, bus_we_n low 2 cycles each, done once, halt_n high after.
- Read burst: addr 0x2000, len 2, bus_data_in 0x11 then 0x22 -> rd_valid twice carrying 11, 22; bus_data_oe never 1; bus_re_n low 2 cycles each.
- Wrap and 256: addr 0xFFFF, len 0 read -> 256 rd_valid pulses, second address 0x0000, last 0x00FE.
- Write stall: wr_valid low 5 cycles during second byte -> SETUP held, bus_we_n stays 1, addr stable, burst resumes correctly.
- Grant timeout: GRANT_TIMEOUT=16, ba held 0 -> error pulse, no strobes, halt_n returns 1, cmd_ready returns 1.
- Async reset mid-STROBE -> bus_we_n=1, all oe=0, halt_n=1 immediately without clock edge; no done; next command runs normally.
